// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with stall hold, bubble, flush and keep-on-bubble bits
// Define PIPE_STAGE_PERF_EN to implement the bubble/hold performance counters.
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter logic [DATA_W-1:0] NOP_DATA = '0,
  parameter logic [DATA_W-1:0] KEEP_MASK = '0,
  parameter int STALL_W = 6,
  parameter int STAGE = 2,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic [STALL_W-1:0] stall,
  input  logic flush,
  input  logic in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic clr_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] hold_cnt
);
  generate
    if (STAGE + 1 >= STALL_W) begin : g_bad_stage
      $error("pipe_stage_reg: STAGE+1 must be below STALL_W");
    end
  endgenerate
  logic up, dn, bubble, hold;
  logic unused_bits;
  assign up = stall[STAGE];
  assign dn = stall[STAGE+1];
  assign bubble = up & ~dn;
  assign hold = up & dn;
  assign unused_bits = ^{stall, clr_cnt};
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid <= 1'b0;
      out_data <= NOP_DATA;
    end else if (!up) begin
      out_valid <= in_valid;
      out_data <= in_data;
    end else if (bubble) begin
      out_valid <= 1'b0;
      out_data <= (NOP_DATA & ~KEEP_MASK) | (out_data & KEEP_MASK);
    end
  end
`ifdef PIPE_STAGE_PERF_EN
  // counters saturate; flush cycles count as neither bubble nor hold
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      bubble_cnt <= '0;
      hold_cnt <= '0;
    end else if (!flush) begin
      if (bubble && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + 1'b1;
      if (hold && !(&hold_cnt)) hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign bubble_cnt = '0;
  assign hold_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vector table plus randomized run against a behavioural model
module tb_pipe_stage_reg;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 0, rst, flush, in_valid, clr_cnt, out_valid;
  logic [5:0] stall;
  logic [7:0] in_data, out_data;
  logic [1:0] bubble_cnt, hold_cnt;
  int errors = 0, checks = 0;
  typedef struct {
    logic rst, flush, clr;
    logic [5:0] stall;
    logic iv;
    logic [7:0] id;
    logic ev;
    logic [7:0] ed;
    int eb, eh;
  } vec_t;
  vec_t tbl[$];
  int mv, md, mb, mh;
  pipe_stage_reg #(.DATA_W(8), .NOP_DATA(8'h00), .KEEP_MASK(8'h80), .STALL_W(6), .STAGE(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .clr_cnt(clr_cnt), .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask
  function automatic vec_t mk(logic r, logic f, logic c, logic [5:0] s, logic iv, logic [7:0] id,
                              logic ev, logic [7:0] ed, int eb, int eh);
    vec_t v;
    v.rst = r; v.flush = f; v.clr = c; v.stall = s; v.iv = iv; v.id = id;
    v.ev = ev; v.ed = ed; v.eb = PERF ? eb : 0; v.eh = PERF ? eh : 0;
    return v;
  endfunction
  task automatic apply(input logic r, input logic f, input logic c, input logic [5:0] s,
                       input logic iv, input logic [7:0] id);
    @(negedge clk);
    rst = r; flush = f; clr_cnt = c; stall = s; in_valid = iv; in_data = id;
    @(posedge clk);
    #1;
  endtask
  // reference: priority rst > flush > load > bubble > hold, counts capped at 3
  task automatic model(input logic r, input logic f, input logic c, input logic [5:0] s,
                       input logic iv, input logic [7:0] id);
    bit up, dn;
    up = s[2]; dn = s[3];
    if (r) begin
      mv = 0; md = 0; mb = 0; mh = 0;
      return;
    end
    if (c) begin
      mb = 0; mh = 0;
    end else if (!f && up) begin
      if (!dn) mb = (mb + 1 > 3) ? 3 : mb + 1;
      else mh = (mh + 1 > 3) ? 3 : mh + 1;
    end
    if (f) begin
      mv = 0; md = 0;
    end else if (!up) begin
      mv = iv; md = id;
    end else if (!dn) begin
      mv = 0; md = md & 8'h80;
    end
  endtask
  initial begin
    rst = 1; flush = 0; clr_cnt = 0; stall = 0; in_valid = 0; in_data = 0;
    tbl.push_back(mk(1, 0, 0, 6'b000000, 1, 8'hAA, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 0, 6'b000000, 1, 8'hAA, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 6'b000000, 1, 8'h5A, 1, 8'h5A, 0, 0));
    tbl.push_back(mk(0, 0, 0, 6'b000000, 1, 8'hC3, 1, 8'hC3, 0, 0));
    tbl.push_back(mk(0, 0, 0, 6'b000100, 1, 8'h11, 0, 8'h80, 1, 0));
    tbl.push_back(mk(0, 0, 0, 6'b000000, 1, 8'hC3, 1, 8'hC3, 1, 0));
    tbl.push_back(mk(0, 0, 0, 6'b001100, 1, 8'h55, 1, 8'hC3, 1, 1));
    tbl.push_back(mk(0, 0, 0, 6'b001100, 0, 8'hAA, 1, 8'hC3, 1, 2));
    tbl.push_back(mk(0, 0, 0, 6'b001100, 1, 8'h55, 1, 8'hC3, 1, 3));
    tbl.push_back(mk(0, 1, 0, 6'b000100, 1, 8'h77, 0, 8'h00, 1, 3));
    tbl.push_back(mk(0, 0, 0, 6'b000000, 1, 8'hC3, 1, 8'hC3, 1, 3));
    tbl.push_back(mk(0, 0, 0, 6'b000100, 1, 8'h01, 0, 8'h80, 2, 3));
    tbl.push_back(mk(0, 0, 0, 6'b000100, 1, 8'h02, 0, 8'h80, 3, 3));
    tbl.push_back(mk(0, 0, 0, 6'b000100, 1, 8'h03, 0, 8'h80, 3, 3));
    tbl.push_back(mk(0, 0, 0, 6'b000100, 1, 8'h04, 0, 8'h80, 3, 3));
    tbl.push_back(mk(0, 0, 0, 6'b000100, 1, 8'h05, 0, 8'h80, 3, 3));
    tbl.push_back(mk(0, 0, 1, 6'b000100, 1, 8'h06, 0, 8'h80, 0, 0));
    tbl.push_back(mk(0, 0, 0, 6'b001100, 1, 8'h07, 0, 8'h80, 0, 1));
    tbl.push_back(mk(0, 0, 0, 6'b110011, 0, 8'h3C, 0, 8'h3C, 0, 1));
    tbl.push_back(mk(0, 0, 0, 6'b000000, 1, 8'h42, 1, 8'h42, 0, 1));
    tbl.push_back(mk(0, 0, 1, 6'b111100, 0, 8'h99, 1, 8'h42, 0, 0));
    tbl.push_back(mk(0, 0, 0, 6'b110100, 0, 8'hFF, 0, 8'h00, 1, 0));
    tbl.push_back(mk(1, 1, 0, 6'b001100, 1, 8'hEE, 0, 8'h00, 0, 0));
    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].flush, tbl[i].clr, tbl[i].stall, tbl[i].iv, tbl[i].id);
      chk("vec_valid", i, out_valid, tbl[i].ev);
      chk("vec_data", i, out_data, tbl[i].ed);
      chk("vec_bubble_cnt", i, bubble_cnt, tbl[i].eb);
      chk("vec_hold_cnt", i, hold_cnt, tbl[i].eh);
    end
    mv = 0; md = 0; mb = 0; mh = 0;
    for (int i = 0; i < 400; i++) begin
      logic r, f, c, iv;
      logic [5:0] s;
      logic [7:0] id;
      r = (i == 0) || ($urandom_range(0, 39) == 0);
      f = ($urandom_range(0, 9) == 0);
      c = ($urandom_range(0, 14) == 0);
      s = 6'($urandom);
      iv = 1'($urandom);
      id = 8'($urandom);
      apply(r, f, c, s, iv, id);
      model(r, f, c, s, iv, id);
      chk("rnd_valid", i, out_valid, mv);
      chk("rnd_data", i, out_data, md);
      chk("rnd_bubble_cnt", i, bubble_cnt, PERF ? mb : 0);
      chk("rnd_hold_cnt", i, hold_cnt, PERF ? mh : 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
